// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: register bus plus AXI4-Stream TX port; slave = uart_tx_mmio, master = core/uart_tx side
interface uart_tx_mmio_if #(parameter int DATA_WIDTH = 8);
  logic                  bus_wen;
  logic                  bus_ren;
  logic [3:0]            bus_addr;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  modport slave (
    input  bus_wen, bus_ren, bus_addr, bus_wdata, m_axis_tready,
    output bus_rdata, m_axis_tdata, m_axis_tvalid
  );
  modport master (
    output bus_wen, bus_ren, bus_addr, bus_wdata, m_axis_tready,
    input  bus_rdata, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: MMIO TX front end (clk, nrst, bus = register bus + stream, tx_busy in, prescale/irq out)
module uart_tx_mmio #(
  parameter int          DATA_WIDTH       = 8,
  parameter int          FIFO_DEPTH       = 16,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd27
) (
  input  logic                 clk,
  input  logic                 nrst,
  uart_tx_mmio_if.slave        bus,
  input  logic                 tx_busy,
  output logic [15:0]          prescale,
  output logic                 irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic                  ovf, en, ie;
  logic [31:0]           rdata_q, status, ctrl, rdata_nxt;
  logic                  empty, full, wr_txdata, push, pop, ovf_set, ovf_clr, ctrl_wr;
  assign empty     = count == '0;
  assign full      = count == CW'(FIFO_DEPTH);
  assign wr_txdata = bus.bus_wen & (bus.bus_addr == 4'h0);
  assign push      = wr_txdata & ~full;
  assign pop       = bus.m_axis_tvalid & bus.m_axis_tready;
  // a dropped write sets OVF in the same cycle a W1C could clear it; set wins
  assign ovf_set   = wr_txdata & full;
  assign ovf_clr   = bus.bus_wen & (bus.bus_addr == 4'h4) & bus.bus_wdata[3];
  assign ctrl_wr   = bus.bus_wen & (bus.bus_addr == 4'h8);
  assign status    = 32'({count, ovf, tx_busy, full, empty});
  assign ctrl      = {14'd0, ie, en, prescale};
  assign rdata_nxt = (bus.bus_addr == 4'h4) ? status : (bus.bus_addr == 4'h8) ? ctrl : '0;
  assign bus.m_axis_tvalid = ~empty & en;
  assign bus.m_axis_tdata  = mem[rd_ptr];
  assign bus.bus_rdata     = rdata_q;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.bus_wdata[DATA_WIDTH-1:0];
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      prescale <= DEFAULT_PRESCALE;
      en       <= 1'b1;
      ie       <= 1'b0;
      rdata_q  <= '0;
      irq      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      ovf   <= ovf_set | (ovf & ~ovf_clr);
      if (ctrl_wr) begin
        prescale <= bus.bus_wdata[15:0];
        en       <= bus.bus_wdata[16];
        ie       <= bus.bus_wdata[17];
      end
      if (bus.bus_ren) rdata_q <= rdata_nxt;
      irq <= ie & empty & ~tx_busy;
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: table-driven register checks plus directed FIFO/stream/irq/reset sequences
module tb_uart_tx_mmio;
  logic        clk = 1'b0;
  logic        nrst;
  logic        tx_busy;
  logic [15:0] prescale;
  logic        irq;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  got[$];
  logic [31:0] rd;
  uart_tx_mmio_if #(.DATA_WIDTH(8)) bif ();
  uart_tx_mmio dut (
    .clk      (clk),
    .nrst     (nrst),
    .bus      (bif.slave),
    .tx_busy  (tx_busy),
    .prescale (prescale),
    .irq      (irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (nrst && bif.m_axis_tvalid && bif.m_axis_tready) got.push_back(bif.m_axis_tdata);
  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic [15:0] exp_ps;
  } vec_t;
  vec_t tbl[10];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bif.bus_wen = 1'b1;
    bif.bus_addr = a;
    bif.bus_wdata = d;
    cyc();
    bif.bus_wen = 1'b0;
  endtask
  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bif.bus_ren = 1'b1;
    bif.bus_addr = a;
    cyc();
    bif.bus_ren = 1'b0;
    d = bif.bus_rdata;
  endtask
  task automatic drain(input string name, input int max);
    int n = 0;
    while (bif.m_axis_tvalid && n < max) begin
      cyc();
      n++;
    end
    check(name, 32'(bif.m_axis_tvalid), 32'd0);
  endtask
  initial begin
    tbl[0] = '{1'b0, 4'h8, 32'h0,         32'h0001_001B, 16'h001B};
    tbl[1] = '{1'b0, 4'h4, 32'h0,         32'h0000_0001, 16'h001B};
    tbl[2] = '{1'b0, 4'h0, 32'h0,         32'h0000_0000, 16'h001B};
    tbl[3] = '{1'b1, 4'h8, 32'hFFFF_1234, 32'h0,         16'h1234};
    tbl[4] = '{1'b0, 4'h8, 32'h0,         32'h0003_1234, 16'h1234};
    tbl[5] = '{1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0,         16'h1234};
    tbl[6] = '{1'b0, 4'hC, 32'h0,         32'h0000_0000, 16'h1234};
    tbl[7] = '{1'b0, 4'h8, 32'h0,         32'h0003_1234, 16'h1234};
    tbl[8] = '{1'b1, 4'h8, 32'h0001_001B, 32'h0,         16'h001B};
    tbl[9] = '{1'b0, 4'h8, 32'h0,         32'h0001_001B, 16'h001B};
    nrst = 1'b0;
    tx_busy = 1'b0;
    bif.bus_wen = 1'b0;
    bif.bus_ren = 1'b0;
    bif.bus_addr = 4'h0;
    bif.bus_wdata = 32'h0;
    bif.m_axis_tready = 1'b0;
    #12;
    check("rst_rdata", bif.bus_rdata, 32'h0);
    check("rst_tvalid", 32'(bif.m_axis_tvalid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_prescale", 32'(prescale), 32'h1B);
    @(negedge clk) nrst = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].addr, tbl[i].data);
        check($sformatf("tbl%0d_prescale", i), 32'(prescale), 32'(tbl[i].exp_ps));
      end else begin
        bus_read(tbl[i].addr, rd);
        check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      end
    end
    // single byte through
    got.delete();
    bif.m_axis_tready = 1'b1;
    bus_write(4'h0, 32'h0000_0055);
    check("single_tvalid", 32'(bif.m_axis_tvalid), 32'h1);
    check("single_tdata", 32'(bif.m_axis_tdata), 32'h55);
    cyc();
    check("single_empty_tvalid", 32'(bif.m_axis_tvalid), 32'h0);
    check("single_pops", got.size(), 1);
    bus_read(4'h4, rd);
    check("single_status", rd, 32'h1);
    // overflow
    bif.m_axis_tready = 1'b0;
    for (int i = 0; i <= 16; i++) bus_write(4'h0, 32'(i));
    bus_read(4'h4, rd);
    check("full_status", rd, 32'h0000_010A);
    check("full_head", 32'(bif.m_axis_tdata), 32'h00);
    got.delete();
    bif.m_axis_tready = 1'b1;
    drain("full_drain", 40);
    bif.m_axis_tready = 1'b0;
    check("full_popcount", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) check($sformatf("full_order%0d", i), 32'(got[i]), 32'(i));
    bus_read(4'h4, rd);
    check("ovf_sticky", rd, 32'h0000_0009);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, rd);
    check("ovf_clear", rd, 32'h1);
    // simultaneous push/pop across pointer wrap
    got.delete();
    for (int i = 0; i < 3; i++) bus_write(4'h0, 32'hA0 + 32'(i));
    for (int k = 0; k < 20; k++) begin
      bif.m_axis_tready = 1'b1;
      bif.bus_wen = 1'b1;
      bif.bus_addr = 4'h0;
      bif.bus_wdata = 32'hA3 + 32'(k);
      cyc();
    end
    bif.bus_wen = 1'b0;
    bif.m_axis_tready = 1'b0;
    bus_read(4'h4, rd);
    check("pp_status", rd, 32'h0000_0030);
    bif.m_axis_tready = 1'b1;
    drain("pp_drain", 10);
    bif.m_axis_tready = 1'b0;
    check("pp_popcount", got.size(), 23);
    for (int i = 0; i < 23 && i < got.size(); i++) check($sformatf("pp_order%0d", i), 32'(got[i]), 32'hA0 + 32'(i));
    // EN gating
    got.delete();
    bus_write(4'h0, 32'hC0);
    bus_write(4'h0, 32'hC1);
    bus_write(4'h8, 32'h0000_001B);
    check("en0_tvalid", 32'(bif.m_axis_tvalid), 32'h0);
    bif.m_axis_tready = 1'b1;
    repeat (5) cyc();
    check("en0_nopops", got.size(), 0);
    bus_read(4'h4, rd);
    check("en0_status", rd, 32'h0000_0020);
    bus_write(4'h8, 32'h0001_001B);
    drain("en1_drain", 10);
    bif.m_axis_tready = 1'b0;
    check("en1_popcount", got.size(), 2);
    if (got.size() == 2) begin
      check("en1_b0", 32'(got[0]), 32'hC0);
      check("en1_b1", 32'(got[1]), 32'hC1);
    end
    // irq and async reset mid-drain
    tx_busy = 1'b1;
    bus_write(4'h8, 32'h0003_001B);
    bif.m_axis_tready = 1'b1;
    bus_write(4'h0, 32'hD0);
    repeat (2) cyc();
    check("irq_busy", 32'(irq), 32'h0);
    tx_busy = 1'b0;
    check("irq_pre", 32'(irq), 32'h0);
    cyc();
    check("irq_set", 32'(irq), 32'h1);
    bif.m_axis_tready = 1'b0;
    bus_write(4'h0, 32'hE0);
    check("irq_hold", 32'(irq), 32'h1);
    cyc();
    check("irq_clear", 32'(irq), 32'h0);
    bus_write(4'h0, 32'hE1);
    bus_write(4'h0, 32'hE2);
    bus_read(4'h8, rd);
    check("ctrl_ie", rd, 32'h0003_001B);
    bif.m_axis_tready = 1'b1;
    cyc();
    #3 nrst = 1'b0;
    #1;
    check("arst_tvalid", 32'(bif.m_axis_tvalid), 32'h0);
    check("arst_rdata", bif.bus_rdata, 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_prescale", 32'(prescale), 32'h1B);
    bif.m_axis_tready = 1'b0;
    @(negedge clk) nrst = 1'b1;
    cyc();
    bus_read(4'h4, rd);
    check("arst_status", rd, 32'h1);
    bus_read(4'h8, rd);
    check("arst_ctrl", rd, 32'h0001_001B);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
